// File: rtl/ps2_keys_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_keys_pkg
// Brief   : Set-2 scan constants and scan-code to letter-code lookup.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_keys_pkg;

  localparam logic [4:0] NO_KEY   = 5'd0;
  localparam logic [4:0] LETTER_A = 5'd1,  LETTER_B = 5'd2,  LETTER_C = 5'd3,  LETTER_D = 5'd4;
  localparam logic [4:0] LETTER_E = 5'd5,  LETTER_F = 5'd6,  LETTER_G = 5'd7,  LETTER_H = 5'd8;
  localparam logic [4:0] LETTER_I = 5'd9,  LETTER_J = 5'd10, LETTER_K = 5'd11, LETTER_L = 5'd12;
  localparam logic [4:0] LETTER_M = 5'd13, LETTER_N = 5'd14, LETTER_O = 5'd15, LETTER_P = 5'd16;
  localparam logic [4:0] LETTER_Q = 5'd17, LETTER_R = 5'd18, LETTER_S = 5'd19, LETTER_T = 5'd20;
  localparam logic [4:0] LETTER_U = 5'd21, LETTER_V = 5'd22, LETTER_W = 5'd23, LETTER_X = 5'd24;
  localparam logic [4:0] LETTER_Y = 5'd25, LETTER_Z = 5'd26;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Shared with the word ROM; anything that is not a letter maps to NO_KEY.
  function automatic logic [4:0] scan_to_letter(input logic [7:0] sc);
    logic [4:0] code;
    case (sc)
      8'h1C: code = LETTER_A;  8'h32: code = LETTER_B;  8'h21: code = LETTER_C;
      8'h23: code = LETTER_D;  8'h24: code = LETTER_E;  8'h2B: code = LETTER_F;
      8'h34: code = LETTER_G;  8'h33: code = LETTER_H;  8'h43: code = LETTER_I;
      8'h3B: code = LETTER_J;  8'h42: code = LETTER_K;  8'h4B: code = LETTER_L;
      8'h3A: code = LETTER_M;  8'h31: code = LETTER_N;  8'h44: code = LETTER_O;
      8'h4D: code = LETTER_P;  8'h15: code = LETTER_Q;  8'h2D: code = LETTER_R;
      8'h1B: code = LETTER_S;  8'h2C: code = LETTER_T;  8'h3C: code = LETTER_U;
      8'h2A: code = LETTER_V;  8'h1D: code = LETTER_W;  8'h22: code = LETTER_X;
      8'h35: code = LETTER_Y;  8'h1A: code = LETTER_Z;
      default: code = NO_KEY;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx
// Brief   : PS/2 line synchronizer, clock glitch filter and 11-bit frame receiver.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byteValid,
  output logic [7:0] rxByte,
  output logic       frameErr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] c_FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] c_TIMEOUT   = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]    r_clkSync, r_dataSync;
  logic [FW-1:0] r_filtCnt;
  logic          r_filtLevel, r_filtPrev;
  logic [1:0]    r_state, w_nextState;
  logic [9:0]    r_shift;
  logic [3:0]    r_bitCnt;
  logic [TW-1:0] r_idleCnt;
  logic          w_bitEdge, w_data, w_frameOk, w_timeout;

  // Lines idle high, so the synchronizers and filter reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkSync   <= 2'b11;
      r_dataSync  <= 2'b11;
      r_filtCnt   <= '0;
      r_filtLevel <= 1'b1;
      r_filtPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_filtPrev <= r_filtLevel;
      if (r_clkSync[1] == r_filtLevel) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == c_FILT_LAST) begin
        r_filtLevel <= r_clkSync[1];
        r_filtCnt   <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + FW'(1);
      end
    end
  end

  assign w_bitEdge = r_filtPrev & ~r_filtLevel;
  assign w_data    = r_dataSync[1];
  assign w_frameOk = (^r_shift[8:0]) & r_shift[9];
  assign w_timeout = (r_idleCnt == c_TIMEOUT);
  assign rxByte    = r_shift[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_idleCnt <= '0;
    end else begin
      if (w_bitEdge)       r_idleCnt <= '0;
      else if (!w_timeout) r_idleCnt <= r_idleCnt + TW'(1);
      if (r_state == S_IDLE && w_bitEdge && !w_data) begin
        r_bitCnt <= '0;
      end else if (r_state == S_SHIFT && w_bitEdge) begin
        r_shift  <= {w_data, r_shift[9:1]};
        r_bitCnt <= r_bitCnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_bitEdge && !w_data) w_nextState = S_SHIFT;
      S_SHIFT: begin
        if (w_bitEdge && r_bitCnt == 4'd9) w_nextState = S_CHECK;
        else if (w_timeout && !w_bitEdge)  w_nextState = S_IDLE;
      end
      S_CHECK: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    byteValid = 1'b0;
    frameErr  = 1'b0;
    case (r_state)
      S_IDLE:  frameErr = w_bitEdge & w_data;
      S_SHIFT: frameErr = w_timeout & ~w_bitEdge;
      S_CHECK: begin
        byteValid = w_frameOk;
        frameErr  = ~w_frameOk;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keystroke_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ps2_keystroke_decoder
// Brief   : Turns PS/2 set-2 letter-key releases into a letter code plus strobe.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_keystroke_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] keystroke,
  output logic       keyReleased,
  output logic       frame_error
);
  import ps2_keys_pkg::*;

  logic       w_byteValid, w_frameErr;
  logic [7:0] w_rxByte;
  logic [4:0] w_letter;
  logic       r_extFlag, r_brkFlag;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byteValid(w_byteValid),
    .rxByte   (w_rxByte),
    .frameErr (w_frameErr)
  );

  assign w_letter = scan_to_letter(w_rxByte);

  // A corrupted frame after F0 drops the pending break so it can never strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keystroke   <= NO_KEY;
      keyReleased <= 1'b0;
      frame_error <= 1'b0;
      r_extFlag   <= 1'b0;
      r_brkFlag   <= 1'b0;
    end else begin
      keyReleased <= 1'b0;
      frame_error <= w_frameErr;
      if (w_byteValid) begin
        if (w_rxByte == SC_EXT) begin
          r_extFlag <= 1'b1;
        end else if (w_rxByte == SC_BREAK) begin
          r_brkFlag <= 1'b1;
        end else begin
          if (r_brkFlag && !r_extFlag && w_letter != NO_KEY) begin
            keystroke   <= w_letter;
            keyReleased <= 1'b1;
          end
          r_brkFlag <= 1'b0;
          r_extFlag <= 1'b0;
        end
      end else if (w_frameErr && r_brkFlag) begin
        r_brkFlag <= 1'b0;
        r_extFlag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keystroke_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_keystroke_decoder
// Brief   : Table, directed and random PS/2 frame checks of the keystroke decoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_keystroke_decoder;

  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int H  = 20;   // PS/2 half bit period in system clocks
  localparam int NV = 22;

  typedef struct {
    logic [7:0] b;
    bit         badPar;
    bit         glitch;
    int         relDelta;
    int         errDelta;
    logic [4:0] key;
  } vec_t;

  logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [4:0] keystroke;
  logic       keyReleased, frame_error;

  int vectors = 0, miscompares = 0;
  int relCount = 0, errCount = 0;
  logic prevRel = 1'b0, prevErr = 1'b0;
  int latency;

  bit         mExt = 1'b0, mBrk = 1'b0;
  logic [4:0] mKey = 5'd0;
  int         mRel = 0, mErr = 0;
  logic [7:0] letterScans [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  vec_t tbl [NV];

  ps2_keystroke_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keystroke  (keystroke),
    .keyReleased(keyReleased),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keyReleased) relCount++;
    if (frame_error) errCount++;
    if (keyReleased && prevRel) begin
      miscompares++;
      $display("FAIL keyReleased_width: high 2 cycles running, required 1");
    end
    if (frame_error && prevErr) begin
      miscompares++;
      $display("FAIL frame_error_width: high 2 cycles running, required 1");
    end
    prevRel = keyReleased;
    prevErr = frame_error;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish within 90000 cycles");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] modelLetter(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (letterScans[i] == b) return 5'(i + 1);
    return 5'd0;
  endfunction

  task automatic modelFrame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      mErr++;
      if (mBrk) begin mBrk = 1'b0; mExt = 1'b0; end
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      if (mBrk && !mExt && modelLetter(b) != 5'd0) begin
        mKey = modelLetter(b);
        mRel++;
      end
      mBrk = 1'b0;
      mExt = 1'b0;
    end
  endtask

  task automatic ps2Bit(input logic d, input bit glitch, input bit lastBit);
    ps2_data = d;
    if (glitch) begin
      repeat (12) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H - 15) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b0;
    for (int k = 1; k <= H; k++) begin
      @(negedge clk);
      if (lastBit && latency < 0 && keyReleased) latency = k;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit glitch, input int nBits);
    logic [10:0] bits;
    bits    = {1'b1, (~^b) ^ badPar, b, 1'b0};
    latency = -1;
    for (int i = 0; i < nBits; i++) ps2Bit(bits[i], glitch, i == 10);
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit badPar, input bit glitch);
    sendFrame(b, badPar, glitch, 11);
    modelFrame(b, !badPar);
  endtask

  initial begin
    int r0, e0, sel;
    logic [7:0] b;
    bit bad;

    tbl = '{
      '{8'h3B, 1'b0, 1'b0, 0, 0, 5'd0},  '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd0},
      '{8'h3B, 1'b0, 1'b0, 1, 0, 5'd10}, '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd10},
      '{8'h44, 1'b0, 1'b0, 1, 0, 5'd15}, '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd15},
      '{8'h42, 1'b0, 1'b0, 1, 0, 5'd11}, '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd11},
      '{8'h24, 1'b0, 1'b0, 1, 0, 5'd5},  '{8'hE0, 1'b0, 1'b0, 0, 0, 5'd5},
      '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd5},  '{8'h1C, 1'b0, 1'b0, 0, 0, 5'd5},
      '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd5},  '{8'h5A, 1'b0, 1'b0, 0, 0, 5'd5},
      '{8'h1C, 1'b1, 1'b0, 0, 1, 5'd5},  '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd5},
      '{8'h1C, 1'b0, 1'b0, 1, 0, 5'd1},  '{8'hF0, 1'b0, 1'b0, 0, 0, 5'd1},
      '{8'h1C, 1'b1, 1'b0, 0, 1, 5'd1},  '{8'h1C, 1'b0, 1'b0, 0, 0, 5'd1},
      '{8'hF0, 1'b0, 1'b1, 0, 0, 5'd1},  '{8'h3B, 1'b0, 1'b1, 1, 0, 5'd10}
    };

    repeat (3) @(negedge clk);
    check("rst_keystroke", keystroke, 5'd0);
    check("rst_keyReleased", keyReleased, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    rst_n = 1'b1;
    repeat (2 * H) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      r0 = relCount;
      e0 = errCount;
      sendByte(tbl[i].b, tbl[i].badPar, tbl[i].glitch);
      check($sformatf("tbl%0d_rel", i), relCount - r0, tbl[i].relDelta);
      check($sformatf("tbl%0d_err", i), errCount - e0, tbl[i].errDelta);
      check($sformatf("tbl%0d_key", i), keystroke, tbl[i].key);
      if (tbl[i].relDelta == 1) check($sformatf("tbl%0d_latency", i), latency, FL + 4);
    end

    // Single clock pulse with data high is a bad start bit.
    e0 = errCount;
    ps2Bit(1'b1, 1'b0, 1'b0);
    repeat (2 * H) @(negedge clk);
    modelFrame(8'h00, 1'b0);
    check("bad_start_err", errCount - e0, 1);

    // Frame abandoned after five data bits must time out.
    r0 = relCount;
    e0 = errCount;
    sendFrame(8'hF0, 1'b0, 1'b0, 6);
    repeat (TO + 50) @(negedge clk);
    modelFrame(8'hF0, 1'b0);
    check("timeout_err", errCount - e0, 1);
    check("timeout_rel", relCount - r0, 0);
    sendByte(8'hF0, 1'b0, 1'b0);
    sendByte(8'h1A, 1'b0, 1'b0);
    check("after_timeout_key", keystroke, 5'd26);
    check("after_timeout_rel", relCount - r0, 1);

    // Reset in the middle of bit 4 of an F0 frame.
    for (int i = 0; i < 5; i++) ps2Bit((i == 0) ? 1'b0 : 1'(8'hF0 >> (i - 1)), 1'b0, 1'b0);
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_keystroke", keystroke, 5'd0);
    check("midrst_keyReleased", keyReleased, 1'b0);
    check("midrst_frame_error", frame_error, 1'b0);
    ps2_clk = 1'b1;
    mBrk = 1'b0;
    mExt = 1'b0;
    mKey = 5'd0;
    repeat (H) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    r0 = relCount;
    sendByte(8'hF0, 1'b0, 1'b0);
    sendByte(8'h3B, 1'b0, 1'b0);
    check("after_rst_key", keystroke, 5'd10);
    check("after_rst_rel", relCount - r0, 1);

    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 45)      b = letterScans[$urandom_range(0, 25)];
      else if (sel < 75) b = 8'hF0;
      else if (sel < 85) b = 8'hE0;
      else               b = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      sendByte(b, bad, 1'b0);
      check($sformatf("rnd%0d_rel", i), relCount, mRel);
      check($sformatf("rnd%0d_err", i), errCount, mErr);
      check($sformatf("rnd%0d_key", i), keystroke, mKey);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
